// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronised RXD, mid-bit sampling, single-entry
// holding register on a valid/ready interface with framing-error and overrun pulses.
`timescale 1ns/1ps
module uart_rx #(
    parameter int unsigned CLK_FREQ_HZ = 12_000_000,
    parameter int unsigned BAUD_RATE   = 115200
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RXD,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned HALF         = CLKS_PER_BIT / 2;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF   = CW'(HALF - 1);

    if (CLKS_PER_BIT < 4) begin : g_cpb_check
        $error("uart_rx: CLKS_PER_BIT must be >= 4");
    end

    typedef enum logic [2:0] {HUNT, IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [1:0]    sync;
    logic          rxd_s;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bitn, bitn_n;
    logic [7:0]    shift, shift_n;
    logic          deliver, ferr;
    logic          cnt_last;

    assign rxd_s    = sync[1];
    assign cnt_last = (cnt == CNT_LAST);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync  <= '1;
            state <= HUNT;
            cnt   <= '0;
            bitn  <= '0;
            shift <= '0;
        end else begin
            sync  <= {sync[0], RXD};
            state <= state_n;
            cnt   <= cnt_n;
            bitn  <= bitn_n;
            shift <= shift_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bitn_n  = bitn;
        shift_n = shift;
        deliver = 1'b0;
        ferr    = 1'b0;
        case (state)
            HUNT: begin
                // Wait for a full bit-time of idle so mid-frame data is never taken as a start bit
                if (!rxd_s) begin
                    cnt_n = '0;
                end else if (cnt_last) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            IDLE: begin
                if (!rxd_s) begin
                    cnt_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n   = '0;
                    bitn_n  = '0;
                    state_n = rxd_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt_last) begin
                    cnt_n   = '0;
                    shift_n = {rxd_s, shift[7:1]};
                    if (bitn == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bitn_n = bitn + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt_last) begin
                    cnt_n = '0;
                    if (rxd_s) begin
                        deliver = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_n = HUNT;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = HUNT;
        endcase
    end

    // A consume on the same edge as a delivery frees the slot for the new byte
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr;
            overrun   <= 1'b0;
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit: serial frames are driven,
// expected bytes queued, and a monitor compares each accepted byte and counts error pulses.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int unsigned CPB = 16;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       RXD = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int fe_seen = 0;
    int ov_seen = 0;
    int exp_fe = 0;
    int exp_ov = 0;
    byte unsigned exp_q[$];

    always #5 CLK = ~CLK;

    uart_rx #(.CLK_FREQ_HZ(16), .BAUD_RATE(1)) dut (
        .CLK(CLK), .RESET(RESET), .RXD(RXD),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .overrun(overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge CLK);
            if (RESET) begin
                if (rx_valid && rx_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %0h expected none", rx_data);
                    end else begin
                        check("rx_byte", rx_data, exp_q.pop_front());
                    end
                end
                if (frame_err) fe_seen++;
                if (overrun) ov_seen++;
                if (frame_err && overrun) begin
                    checks++;
                    errors++;
                    $display("FAIL pulse_overlap: got both set expected at most one");
                end
            end
        end
    endtask

    task automatic send_bit(input logic b);
        RXD = b;
        repeat (CPB) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        RXD = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic settle(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge CLK);
        check({name, "_pending"}, exp_q.size(), 0);
        repeat (4) @(negedge CLK);
        check({name, "_frame_err_count"}, fe_seen, exp_fe);
        check({name, "_overrun_count"}, ov_seen, exp_ov);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] b;
        logic       bad;
        fork
            monitor();
        join_none

        repeat (3) @(negedge CLK);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        RESET = 1'b1;
        idle(24);

        // 1: plain byte
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        idle(4);
        settle("t1");

        // 2: short glitch rejected, then a real byte
        RXD = 1'b0;
        repeat (4) @(negedge CLK);
        idle(24);
        settle("t2_glitch");
        exp_q.push_back(8'hA3);
        send_frame(8'hA3, 1'b1);
        idle(4);
        settle("t2");

        // 3: framing error with line held low, then recovery
        send_frame(8'hA5, 1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        exp_fe++;
        idle(24);
        settle("t3_ferr");
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        idle(4);
        settle("t3");

        // 4: overrun while holding register is full
        rx_ready = 1'b0;
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        idle(4);
        check("t4_valid_held", rx_valid, 1);
        send_frame(8'h34, 1'b1);
        exp_ov++;
        idle(4);
        check("t4_valid_still", rx_valid, 1);
        check("t4_data_held", rx_data, 8'h12);
        check("t4_overrun_count", ov_seen, exp_ov);
        rx_ready = 1'b1;
        repeat (2) @(negedge CLK);
        check("t4_valid_dropped", rx_valid, 0);
        check("t4_data_after", rx_data, 8'h12);
        settle("t4");

        // 5: reset during data bit 3 of 0x0F
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        RXD = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        check("t5_rst_valid", rx_valid, 0);
        check("t5_rst_data", rx_data, 8'h00);
        check("t5_rst_frame_err", frame_err, 0);
        check("t5_rst_overrun", overrun, 0);
        RESET = 1'b1;
        repeat (CPB - 5) @(negedge CLK);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        send_bit(1'b1);
        idle(24);
        settle("t5_remainder");
        exp_q.push_back(8'hC6);
        send_frame(8'hC6, 1'b1);
        idle(4);
        settle("t5");

        // 6: back-to-back frames
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(4);
        settle("t6");

        // randomized frames, gaps and occasional bad stop bits
        for (int n = 0; n < 30; n++) begin
            b   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 5) == 0);
            if (bad) begin
                send_frame(b, 1'b0);
                exp_fe++;
                idle(40 + $urandom_range(0, 10));
            end else begin
                exp_q.push_back(b);
                send_frame(b, 1'b1);
                idle($urandom_range(0, 24));
            end
        end
        idle(4);
        settle("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
